// File: rtl/sort4_pkg.sv
// Shared types and constants for the four-element sorter: FSM state encoding,
// number of compare-and-swap steps and the fixed pair schedule.
package sort4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_STEPS = 6;
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  // Lower element index of the pair compared at each step, step 0 in the LSBs.
  // Schedule: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1); the upper index is lower+1.
  localparam logic [11:0] PAIR_LO_TABLE = {2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

  // Look up the lower pair index for a step; out-of-range steps map to pair 0.
  function automatic logic [1:0] pair_lo(input logic [2:0] step);
    logic [1:0] lo;
    if (step <= LAST_STEP) begin
      lo = PAIR_LO_TABLE[{step, 1'b0} +: 2];
    end else begin
      lo = 2'd0;
    end
    return lo;
  endfunction

endpackage

// File: rtl/sort4_ctrl_if.sv
// Handshake and data bus of the four-element sorter.
// master: the requester (drives start and elements); slave: the sorter.
interface sort4_ctrl_if #(
  parameter int DATA_W = 3
);

  logic              start;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic [DATA_W-1:0] out3;

  modport master (
    output start, in0, in1, in2, in3,
    input  busy, done, out0, out1, out2, out3
  );

  modport slave (
    input  start, in0, in1, in2, in3,
    output busy, done, out0, out1, out2, out3
  );

endinterface

// File: rtl/sort4_ctrl_cmp_swap.sv
// Combinational compare-and-swap cell shared by every sort step.
// Ascending by default; descending when SORT4_DESC_EN is defined.
// Equal operands are never swapped.
module cmp_swap #(
  parameter int DATA_W = 3
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] first,
  output logic [DATA_W-1:0] second,
  output logic              swap
);

  // Decide whether the pair is out of order and emit it in the wanted order.
  always_comb begin
`ifdef SORT4_DESC_EN
    swap = (a < b);
`else
    swap = (a > b);
`endif
    if (swap) begin
      first  = b;
      second = a;
    end else begin
      first  = a;
      second = b;
    end
  end

endmodule

// File: rtl/sort4_ctrl.sv
// Four-element sorter: loads four elements on start, runs a fixed six-step
// bubble schedule through one shared compare-and-swap cell, then publishes
// the result with a one-cycle done pulse. Fixed latency regardless of data.
// Optional macro SORT4_DESC_EN selects descending order.
module sort4_ctrl
  import sort4_pkg::*;
#(
  parameter int DATA_W = 3
) (
  input logic         clk,
  input logic         rst,
  sort4_ctrl_if.slave bus
);

  state_t            state_r;
  state_t            state_s;
  logic [2:0]        step_r;
  logic [2:0]        step_s;
  logic [DATA_W-1:0] e_r [4];
  logic [DATA_W-1:0] e_s [4];
  logic [DATA_W-1:0] out_r [4];
  logic              done_r;
  logic              done_s;
  logic              busy_r;
  logic              busy_s;
  logic              out_ld_s;

  logic [1:0]        sel_lo_s;
  logic [1:0]        sel_hi_s;
  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] cs_first_s;
  logic [DATA_W-1:0] cs_second_s;
  logic              cs_swap_s;

  // Select the pair for the current step and route it to the shared cell.
  always_comb begin
    sel_lo_s = pair_lo(step_r);
    sel_hi_s = sel_lo_s + 2'd1;
    op_a_s   = e_r[sel_lo_s];
    op_b_s   = e_r[sel_hi_s];
  end

  cmp_swap #(
    .DATA_W (DATA_W)
  ) u_cmp_swap (
    .a      (op_a_s),
    .b      (op_b_s),
    .first  (cs_first_s),
    .second (cs_second_s),
    .swap   (cs_swap_s)
  );

  // Next-state, element update and output-load decisions.
  always_comb begin
    state_s  = state_r;
    step_s   = step_r;
    done_s   = 1'b0;
    out_ld_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e_s[i] = e_r[i];
    end
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = SORT;
          step_s  = 3'd0;
          e_s[0]  = bus.in0;
          e_s[1]  = bus.in1;
          e_s[2]  = bus.in2;
          e_s[3]  = bus.in3;
        end else begin
          state_s = IDLE;
        end
      end
      SORT: begin
        if (cs_swap_s) begin
          e_s[sel_lo_s] = cs_first_s;
          e_s[sel_hi_s] = cs_second_s;
        end else begin
          e_s[sel_lo_s] = e_r[sel_lo_s];
        end
        if (step_r == LAST_STEP) begin
          state_s  = DONE;
          step_s   = 3'd0;
          done_s   = 1'b1;
          out_ld_s = 1'b1;
        end else begin
          step_s = step_r + 3'd1;
        end
      end
      DONE: begin
        // start is ignored here; DONE never accepts a new request
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        step_s  = 3'd0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, element and output registers with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      step_r  <= 3'd0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        e_r[i]   <= '0;
        out_r[i] <= '0;
      end
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      for (int i = 0; i < 4; i++) begin
        e_r[i] <= e_s[i];
        if (out_ld_s) begin
          // capture including the final step's swap
          out_r[i] <= e_s[i];
        end else begin
          out_r[i] <= out_r[i];
        end
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.out0 = out_r[0];
  assign bus.out1 = out_r[1];
  assign bus.out2 = out_r[2];
  assign bus.out3 = out_r[3];

endmodule

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 Parameter DATA_W, default 3, element width in bits.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to sort; sampled only in IDLE.
REQ-005 in0..in3  input  DATA_W each  unsigned elements, sampled on the accepted start.
REQ-006 busy  output  1  high while in SORT or DONE.
REQ-007 done  output  1  one-cycle pulse; out0..out3 valid from this cycle on.
REQ-008 out0..out3  output  DATA_W each  sorted elements; out0 holds the first-order element.

Function
REQ-009 FSM states SHALL be IDLE, SORT and DONE.
REQ-010 In IDLE, start=1 SHALL load in0..in3 into the element registers e0..e3, clear step to 0 and move to SORT on the same edge.
REQ-011 SORT SHALL do one compare-and-swap per cycle on a fixed bubble schedule indexed by step 0..5: pairs (0,1),(1,2),(2,3),(0,1),(1,2),(0,1).
REQ-012 Each compare SHALL swap the pair only if the lower-index element is strictly greater than the higher-index element (ascending order); equal elements SHALL NOT be swapped.
REQ-013 The comparison SHALL be an unsigned DATA_W-bit magnitude compare with no width extension and no wrap.
REQ-014 After step 5 the FSM SHALL enter DONE; DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-015 Latency SHALL be fixed: done is high exactly 7 cycles after the cycle in which start was accepted, whatever the data.
REQ-016 out0..out3 SHALL be driven from e0..e3 only when DONE is entered, and SHALL hold until the next DONE.
REQ-017 start in SORT or DONE SHALL be ignored: no reload, no change to the schedule.
REQ-018 In IDLE, start held high SHALL start a new sort every 8 cycles; done from the previous sort and the new accept cannot coincide, because DONE is never the accepting state.
REQ-019 busy SHALL equal (state != IDLE).

Reset
REQ-020 rst=1 at a clock edge SHALL force IDLE, step=0, e0..e3=0, out0..out3=0, done=0 and busy=0.
REQ-021 rst SHALL take priority over start and over any in-progress sort.
REQ-022 A sort interrupted by reset SHALL be abandoned with no done pulse.

Configuration
REQ-023 Macro SORT4_DESC_EN: when defined, the swap condition SHALL be lower-index element strictly less than higher-index element (descending); when undefined, the order SHALL be ascending per REQ-012.
REQ-024 Latency, handshake and reset behaviour SHALL be identical with and without SORT4_DESC_EN.

Structure
REQ-025 Package sort4_pkg SHALL hold the state enum (IDLE/SORT/DONE), the constant NUM_STEPS=6 and the pair-index schedule table.
REQ-026 One sub-module, cmp_swap, SHALL take two DATA_W operands and return the ordered pair plus a swap flag, combinationally.
REQ-027 Exactly one cmp_swap SHALL be instantiated and shared by all steps through operand multiplexers.

Verification
REQ-028 Reset: assert rst for 2 cycles -> out0..out3=0, done=0, busy=0.
REQ-029 in={5,2,7,1}, start pulse -> busy on the next cycle; done exactly 7 cycles after the accept; out={1,2,5,7}.
REQ-030 Sorted input {0,1,2,3} and duplicates {4,4,0,7} -> {0,1,2,3} and {0,4,4,7}, both at the 7-cycle latency.
REQ-031 Start {7,6,5,4}; at step 2 pulse start with {0,0,0,0} -> ignored; result {4,5,6,7}, one done pulse only.
REQ-032 Start {3,1,2,0}; assert rst at step 3 -> IDLE, outputs 0, no done; a new start with {6,0,6,1} -> {0,1,6,6}.
REQ-033 Build with SORT4_DESC_EN defined, in={5,2,7,1} -> out={7,5,2,1}, same latency.
